// File: rtl/imm_extend_pipe_pkg.sv
// rtl/imm_extend_pipe_pkg.sv - shared mode codes and default widths for the immediate extender
package imm_extend_pipe_pkg;

  localparam int DEF_SIZE_IN  = 16;
  localparam int DEF_SIZE_OUT = 32;

  typedef enum logic [1:0] {
    MODE_ZX   = 2'b00,
    MODE_SX   = 2'b01,
    MODE_LU   = 2'b10,
    MODE_SXSH = 2'b11
  } ext_mode_e;

endpackage

// File: rtl/imm_extend_pipe_ext_core.sv
// rtl/imm_extend_pipe_ext_core.sv - combinational immediate extension mode mux
module imm_extend_pipe_ext_core
  import imm_extend_pipe_pkg::*;
#(
  parameter int SIZE_IN  = DEF_SIZE_IN,
  parameter int SIZE_OUT = DEF_SIZE_OUT,
  parameter int SHIFT    = 2
) (
  input  logic [1:0]          mode_i,
  input  logic [SIZE_IN-1:0]  imm_i,
  output logic [SIZE_OUT-1:0] ext_o
);

  localparam int E = SIZE_OUT - SIZE_IN;

  logic [SIZE_OUT-1:0] zx;
  logic [SIZE_OUT-1:0] sx;
  logic [SIZE_OUT-1:0] lu;

  assign zx = {{E{1'b0}}, imm_i};
  assign sx = {{E{imm_i[SIZE_IN-1]}}, imm_i};
  assign lu = {imm_i, {E{1'b0}}};

  // Select the widened value; the shifted form drops bits shifted past the MSB
  always_comb begin
    ext_o = zx;
    case (ext_mode_e'(mode_i))
      MODE_ZX:   ext_o = zx;
      MODE_SX:   ext_o = sx;
      MODE_LU:   ext_o = lu;
      MODE_SXSH: ext_o = sx << SHIFT;
      default:   ext_o = zx;
    endcase
  end

endmodule

// File: rtl/imm_extend_pipe.sv
// rtl/imm_extend_pipe.sv - pipelined immediate extender with output FIFO and flush
module imm_extend_pipe
  import imm_extend_pipe_pkg::*;
#(
  parameter int SIZE_IN  = DEF_SIZE_IN,
  parameter int SIZE_OUT = DEF_SIZE_OUT,
  parameter int SHIFT    = 2,
  parameter int DEPTH    = 2,
  parameter int TAG_W    = 5,
  localparam int CNT_W   = $clog2(DEPTH + 1)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                flush,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [1:0]          in_mode,
  input  logic [SIZE_IN-1:0]  in_imm,
  input  logic [TAG_W-1:0]    in_tag,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [SIZE_OUT-1:0] out_data,
  output logic [TAG_W-1:0]    out_tag,
  output logic [CNT_W-1:0]    count
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int ENT_W = SIZE_OUT + TAG_W;
  localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(DEPTH - 1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);

  logic [ENT_W-1:0]    mem_q [DEPTH];
  logic [PTR_W-1:0]    wr_q, wr_d;
  logic [PTR_W-1:0]    rd_q, rd_d;
  logic [CNT_W-1:0]    count_q, count_d;
  // Forces zero on the output after reset until the first entry lands,
  // since storage itself is never cleared
  logic                zero_q, zero_d;
  logic [SIZE_OUT-1:0] ext;
  logic [ENT_W-1:0]    head;
  logic                push;
  logic                pop;

  imm_extend_pipe_ext_core #(
    .SIZE_IN  (SIZE_IN),
    .SIZE_OUT (SIZE_OUT),
    .SHIFT    (SHIFT)
  ) u_ext_core (
    .mode_i (in_mode),
    .imm_i  (in_imm),
    .ext_o  (ext)
  );

  // in_ready depends only on the registered count, so a full FIFO refuses a push even when popping
  assign in_ready  = (count_q < CNT_FULL);
  assign out_valid = (count_q != '0);
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;
  assign count     = count_q;
  assign head      = mem_q[rd_q];
  assign out_data  = zero_q ? '0 : head[ENT_W-1:TAG_W];
  assign out_tag   = zero_q ? '0 : head[TAG_W-1:0];

  // Pointer and occupancy next state; flush overrides push and pop
  always_comb begin
    wr_d    = wr_q;
    rd_d    = rd_q;
    count_d = count_q;
    zero_d  = zero_q;
    if (flush) begin
      wr_d    = '0;
      rd_d    = '0;
      count_d = '0;
    end else begin
      if (push) begin
        wr_d   = (wr_q == PTR_LAST) ? '0 : wr_q + 1'b1;
        zero_d = 1'b0;
      end
      if (pop) begin
        rd_d = (rd_q == PTR_LAST) ? '0 : rd_q + 1'b1;
      end
      case ({push, pop})
        2'b10:   count_d = count_q + 1'b1;
        2'b01:   count_d = count_q - 1'b1;
        default: count_d = count_q;
      endcase
    end
  end

  // Control state register with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_q    <= '0;
      rd_q    <= '0;
      count_q <= '0;
      zero_q  <= 1'b1;
    end else begin
      wr_q    <= wr_d;
      rd_q    <= rd_d;
      count_q <= count_d;
      zero_q  <= zero_d;
    end
  end

  // Entry storage; written on accepted pushes only, never cleared
  always_ff @(posedge clk) begin
    if (rst_n && !flush && push) begin
      mem_q[wr_q] <= {ext, in_tag};
    end
  end

endmodule

// File: tb/tb_imm_extend_pipe.sv
// tb/tb_imm_extend_pipe.sv - scoreboard bench for imm_extend_pipe at default and small parameters
module tb_imm_extend_pipe;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  int n_pass  = 0;
  int n_total = 0;

  // default instance: SIZE_IN=16, SIZE_OUT=32, DEPTH=2
  logic        a_flush, a_in_valid, a_in_ready, a_out_valid, a_out_ready;
  logic [1:0]  a_in_mode, a_count;
  logic [15:0] a_in_imm;
  logic [4:0]  a_in_tag, a_out_tag;
  logic [31:0] a_out_data;

  // small instance: SIZE_IN=8, SIZE_OUT=16, DEPTH=3
  logic        b_flush, b_in_valid, b_in_ready, b_out_valid, b_out_ready;
  logic [1:0]  b_in_mode, b_count;
  logic [7:0]  b_in_imm;
  logic [4:0]  b_in_tag, b_out_tag;
  logic [15:0] b_out_data;

  logic [36:0] a_q[$];
  logic [20:0] b_q[$];
  logic [36:0] a_mon_exp;
  logic [20:0] b_mon_exp;

  imm_extend_pipe u_a (
    .clk(clk), .rst_n(rst_n), .flush(a_flush),
    .in_valid(a_in_valid), .in_ready(a_in_ready), .in_mode(a_in_mode),
    .in_imm(a_in_imm), .in_tag(a_in_tag),
    .out_valid(a_out_valid), .out_ready(a_out_ready),
    .out_data(a_out_data), .out_tag(a_out_tag), .count(a_count)
  );

  imm_extend_pipe #(.SIZE_IN(8), .SIZE_OUT(16), .SHIFT(2), .DEPTH(3), .TAG_W(5)) u_b (
    .clk(clk), .rst_n(rst_n), .flush(b_flush),
    .in_valid(b_in_valid), .in_ready(b_in_ready), .in_mode(b_in_mode),
    .in_imm(b_in_imm), .in_tag(b_in_tag),
    .out_valid(b_out_valid), .out_ready(b_out_ready),
    .out_data(b_out_data), .out_tag(b_out_tag), .count(b_count)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // starts at posedge+1, returns at posedge+1 after the accepting edge
  task automatic a_push(input logic [1:0] m, input logic [15:0] imm, input logic [4:0] tag,
                        input logic [31:0] exp);
    int n = 0;
    a_in_valid = 1'b1; a_in_mode = m; a_in_imm = imm; a_in_tag = tag;
    @(negedge clk);
    while (!a_in_ready && n < 50) begin n++; @(negedge clk); end
    if (!a_in_ready) check("a_push_timeout", 64'd0, 64'd1);
    else a_q.push_back({exp, tag});
    @(posedge clk); #1;
    a_in_valid = 1'b0;
  endtask

  task automatic b_push(input logic [1:0] m, input logic [7:0] imm, input logic [4:0] tag,
                        input logic [15:0] exp);
    int n = 0;
    b_in_valid = 1'b1; b_in_mode = m; b_in_imm = imm; b_in_tag = tag;
    @(negedge clk);
    while (!b_in_ready && n < 50) begin n++; @(negedge clk); end
    if (!b_in_ready) check("b_push_timeout", 64'd0, 64'd1);
    else b_q.push_back({exp, tag});
    @(posedge clk); #1;
    b_in_valid = 1'b0;
  endtask

  task automatic a_drain1();
    @(posedge clk); #1 a_out_ready = 1'b1;
    @(posedge clk); #1 a_out_ready = 1'b0;
  endtask

  task automatic wait_empty();
    int n = 0;
    while ((a_q.size() != 0 || b_q.size() != 0) && n < 50) begin n++; @(posedge clk); end
    #1;
    check("drain_a_empty", 64'(a_q.size()), 64'd0);
    check("drain_b_empty", 64'(b_q.size()), 64'd0);
  endtask

  // monitors: compare the head against the scoreboard whenever it is taken
  initial forever begin
    @(negedge clk);
    if (rst_n === 1'b1 && a_flush === 1'b0 && a_out_valid === 1'b1 && a_out_ready === 1'b1) begin
      if (a_q.size() == 0) check("a_unexpected_out", 64'(a_out_data), 64'hdead);
      else begin
        a_mon_exp = a_q.pop_front();
        check("a_data", 64'(a_out_data), 64'(a_mon_exp[36:5]));
        check("a_tag", 64'(a_out_tag), 64'(a_mon_exp[4:0]));
      end
    end
  end

  initial forever begin
    @(negedge clk);
    if (rst_n === 1'b1 && b_flush === 1'b0 && b_out_valid === 1'b1 && b_out_ready === 1'b1) begin
      if (b_q.size() == 0) check("b_unexpected_out", 64'(b_out_data), 64'hdead);
      else begin
        b_mon_exp = b_q.pop_front();
        check("b_data", 64'(b_out_data), 64'(b_mon_exp[20:5]));
        check("b_tag", 64'(b_out_tag), 64'(b_mon_exp[4:0]));
      end
    end
  end

  logic [1:0]  s_mode [10] = '{2'd0, 2'd0, 2'd1, 2'd1, 2'd2, 2'd2, 2'd3, 2'd3, 2'd3, 2'd1};
  logic [15:0] s_imm  [10] = '{16'h0000, 16'hFFFF, 16'hFFFF, 16'h7FFF, 16'h0001,
                               16'hABCD, 16'h0001, 16'h8000, 16'hC000, 16'h5555};
  logic [31:0] s_exp  [10] = '{32'h0000_0000, 32'h0000_FFFF, 32'hFFFF_FFFF, 32'h0000_7FFF,
                               32'h0001_0000, 32'hABCD_0000, 32'h0000_0004, 32'hFFFE_0000,
                               32'hFFFF_0000, 32'h0000_5555};

  initial begin
    rst_n = 1'b0;
    a_flush = 0; a_in_valid = 0; a_in_mode = 0; a_in_imm = 0; a_in_tag = 0; a_out_ready = 0;
    b_flush = 0; b_in_valid = 0; b_in_mode = 0; b_in_imm = 0; b_in_tag = 0; b_out_ready = 0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    check("rst_a_count", 64'(a_count), 64'd0);
    check("rst_a_out_valid", 64'(a_out_valid), 64'd0);
    check("rst_a_in_ready", 64'(a_in_ready), 64'd1);
    check("rst_a_out_data", 64'(a_out_data), 64'd0);
    check("rst_a_out_tag", 64'(a_out_tag), 64'd0);
    check("rst_b_in_ready", 64'(b_in_ready), 64'd1);
    @(posedge clk); #1;

    // ZX and SX with one-cycle latency
    a_push(2'd0, 16'h8001, 5'd1, 32'h0000_8001);
    @(negedge clk);
    check("lat_zx_valid", 64'(a_out_valid), 64'd1);
    check("lat_zx_data", 64'(a_out_data), 64'h0000_8001);
    a_drain1();
    a_push(2'd1, 16'h8001, 5'd2, 32'hFFFF_8001);
    @(negedge clk);
    check("lat_sx_valid", 64'(a_out_valid), 64'd1);
    check("lat_sx_data", 64'(a_out_data), 64'hFFFF_8001);
    a_drain1();

    // LU and SXSH
    a_out_ready = 1'b1;
    a_push(2'd2, 16'h1234, 5'd3, 32'h1234_0000);
    a_push(2'd3, 16'hFFFF, 5'd4, 32'hFFFF_FFFC);
    a_push(2'd3, 16'h7FFF, 5'd5, 32'h0001_FFFC);
    wait_empty();
    a_out_ready = 1'b0;

    // backpressure: full FIFO refuses input, head stays put
    a_push(2'd0, 16'h1234, 5'd3, 32'h0000_1234);
    a_push(2'd1, 16'h8765, 5'd4, 32'hFFFF_8765);
    check("bp_count", 64'(a_count), 64'd2);
    check("bp_in_ready", 64'(a_in_ready), 64'd0);
    a_in_valid = 1'b1; a_in_mode = 2'd2; a_in_imm = 16'h00FF; a_in_tag = 5'd5;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("bp_hold_ready", 64'(a_in_ready), 64'd0);
      check("bp_hold_data", 64'(a_out_data), 64'h0000_1234);
      check("bp_hold_tag", 64'(a_out_tag), 64'd3);
    end
    @(posedge clk); #1 a_out_ready = 1'b1;
    a_push(2'd2, 16'h00FF, 5'd5, 32'h00FF_0000);
    wait_empty();

    // streaming: one per cycle, count holds at 1
    for (int i = 0; i < 10; i++) begin
      a_push(s_mode[i], s_imm[i], 5'(i + 8), s_exp[i]);
      check("stream_count", 64'(a_count), 64'd1);
    end
    wait_empty();
    a_out_ready = 1'b0;

    // flush when full, with a push attempt
    a_push(2'd0, 16'h0011, 5'd1, 32'h0000_0011);
    a_push(2'd0, 16'h0022, 5'd2, 32'h0000_0022);
    a_in_valid = 1'b1; a_in_imm = 16'h0033; a_flush = 1'b1;
    @(posedge clk); #1 a_flush = 1'b0; a_in_valid = 1'b0; a_q.delete();
    @(negedge clk);
    check("flush_full_count", 64'(a_count), 64'd0);
    check("flush_full_valid", 64'(a_out_valid), 64'd0);
    check("flush_full_ready", 64'(a_in_ready), 64'd1);
    @(posedge clk); #1;

    // flush beats an accepted push at count=1
    a_push(2'd0, 16'h0044, 5'd4, 32'h0000_0044);
    a_in_valid = 1'b1; a_in_imm = 16'h0055; a_flush = 1'b1;
    @(posedge clk); #1 a_flush = 1'b0; a_in_valid = 1'b0; a_q.delete();
    @(negedge clk);
    check("flush_push_count", 64'(a_count), 64'd0);
    check("flush_push_valid", 64'(a_out_valid), 64'd0);
    @(posedge clk); #1;

    // reset mid-operation with a push pending
    a_push(2'd1, 16'h8888, 5'd7, 32'hFFFF_8888);
    a_push(2'd1, 16'h9999, 5'd9, 32'hFFFF_9999);
    a_in_valid = 1'b1; a_in_imm = 16'h0066; rst_n = 1'b0;
    @(posedge clk); #1 rst_n = 1'b1; a_in_valid = 1'b0; a_q.delete();
    @(negedge clk);
    check("reset_count", 64'(a_count), 64'd0);
    check("reset_valid", 64'(a_out_valid), 64'd0);
    check("reset_ready", 64'(a_in_ready), 64'd1);
    check("reset_data", 64'(a_out_data), 64'd0);
    check("reset_tag", 64'(a_out_tag), 64'd0);
    @(posedge clk); #1 a_out_ready = 1'b1;
    a_push(2'd2, 16'hBEEF, 5'd30, 32'hBEEF_0000);
    wait_empty();
    a_out_ready = 1'b0;

    // small parameter set: fill DEPTH=3, drain, then stream across the wrap
    b_push(2'd1, 8'h80, 5'd1, 16'hFF80);
    b_push(2'd0, 8'h80, 5'd2, 16'h0080);
    b_push(2'd2, 8'h12, 5'd3, 16'h1200);
    check("b_full_count", 64'(b_count), 64'd3);
    check("b_full_ready", 64'(b_in_ready), 64'd0);
    b_out_ready = 1'b1;
    wait_empty();
    b_push(2'd3, 8'hFF, 5'd4, 16'hFFFC);
    b_push(2'd3, 8'h7F, 5'd5, 16'h01FC);
    b_push(2'd1, 8'h81, 5'd6, 16'hFF81);
    b_push(2'd2, 8'h3C, 5'd7, 16'h3C00);
    b_push(2'd3, 8'h40, 5'd8, 16'h0100);
    wait_empty();
    check("b_end_count", 64'(b_count), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
